// File: rtl/connect_four_renderer.sv
// connect_four_renderer: 2-stage pipelined Connect Four pixel renderer with drop animation.
// Define CF_WIN_BLINK_EN to blink the winning discs while game_over is set.
module connect_four_renderer #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CELL_LOG2 = 5,
  parameter int ORIGIN_X = 192,
  parameter int ORIGIN_Y = 112,
  parameter int RADIUS = 14,
  parameter int FALL_STEP = 4,
  parameter int BLINK_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           x_count,
  input  logic [9:0]           y_count,
  input  logic                 frame_start,
  output logic [2:0]           cell_rd_row,
  output logic [2:0]           cell_rd_col,
  input  logic [1:0]           cell_rd_data,
  input  logic [2:0]           cursor_col,
  input  logic [1:0]           current_player,
  input  logic                 game_over,
  input  logic [ROWS*COLS-1:0] win_mask,
  input  logic                 anim_start,
  input  logic [2:0]           anim_col,
  input  logic [2:0]           anim_row,
  input  logic [1:0]           anim_player,
  output logic                 anim_busy,
  output logic                 anim_done,
  output logic [1:0]           vga_r,
  output logic [1:0]           vga_g,
  output logic [1:0]           vga_b
);
  localparam int CELL = 1 << CELL_LOG2;
  localparam int HALF = CELL / 2;
  localparam int CUR_Y = ORIGIN_Y - 16 - CELL;
  localparam int START_Y = CUR_Y + HALF;
  localparam int SQW = 2 * CELL_LOG2 + 1;
  localparam int IW = $clog2(ROWS * COLS);
  localparam logic [5:0] BG = 6'b011101;
  localparam logic [5:0] BOARD = 6'b000011;
  localparam logic [5:0] P1 = 6'b111100;
  localparam logic [5:0] P2 = 6'b110000;
  typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;
  state_t state, state_n;
  logic [9:0] fall_y, fall_y_n, step_y;
  logic [2:0] a_col, a_row;
  logic [1:0] a_player, s_cp;
  logic done_n, landed;
  logic act, board, cur, fall, hide;
  logic s_act, s_board, s_bdisc, s_cur, s_fall, s_hide;
  int rx, ry, cy, fx, fy;
  logic [5:0] rgb;

  // Offsets are measured from the cell's top-left corner; the disc is centred at HALF.
  function automatic logic in_disc(input logic [CELL_LOG2-1:0] ox, input logic [CELL_LOG2-1:0] oy);
    logic [CELL_LOG2-1:0] ax, ay;
    ax = ox[CELL_LOG2-1] ? ox - CELL_LOG2'(HALF) : CELL_LOG2'(HALF) - ox;
    ay = oy[CELL_LOG2-1] ? oy - CELL_LOG2'(HALF) : CELL_LOG2'(HALF) - oy;
    return SQW'(ax) * SQW'(ax) + SQW'(ay) * SQW'(ay) <= SQW'(RADIUS * RADIUS);
  endfunction

  function automatic logic [5:0] piece(input logic [1:0] p);
    return p == 2'b01 ? P1 : p == 2'b10 ? P2 : BG;
  endfunction

  function automatic logic [9:0] target(input logic [2:0] row);
    return 10'(ORIGIN_Y + (ROWS - 1 - int'(row)) * CELL + HALF);
  endfunction

  assign anim_busy = state != IDLE;

  always_comb begin
    rx = int'(x_count) - ORIGIN_X;
    ry = int'(y_count) - ORIGIN_Y;
    cy = int'(y_count) - CUR_Y;
    fx = int'(x_count) - (ORIGIN_X + int'(a_col) * CELL + HALF);
    fy = int'(y_count) - int'(fall_y);
    act = x_count < 10'd640 && y_count < 10'd480;
    board = rx >= 0 && rx < COLS * CELL && ry >= 0 && ry < ROWS * CELL;
    cell_rd_col = board ? 3'(rx >> CELL_LOG2) : 3'd0;
    cell_rd_row = board ? 3'(ROWS - 1 - (ry >> CELL_LOG2)) : 3'd0;
    cur = !game_over && !anim_busy && rx >= 0 && rx < COLS * CELL && cy >= 0 && cy < CELL &&
          (rx >> CELL_LOG2) == int'(cursor_col) && in_disc(rx[CELL_LOG2-1:0], cy[CELL_LOG2-1:0]);
    fall = anim_busy && fx > -HALF && fx < HALF && fy > -HALF && fy < HALF &&
           in_disc(CELL_LOG2'(fx + HALF), CELL_LOG2'(fy + HALF));
  end

`ifdef CF_WIN_BLINK_EN
  logic [BLINK_LOG2:0] blink;
  logic [IW-1:0] widx;
  assign widx = IW'(int'(cell_rd_row) * COLS + int'(cell_rd_col));
  assign hide = game_over && blink[BLINK_LOG2] && win_mask[widx];
  always_ff @(posedge clk)
    if (rst) blink <= '0;
    else if (frame_start) blink <= blink + 1'b1;
`else
  logic unused_win;
  assign unused_win = ^win_mask;
  assign hide = 1'b0;
`endif

  always_ff @(posedge clk)
    if (rst) begin
      {s_act, s_board, s_bdisc, s_cur, s_fall, s_hide} <= '0;
      s_cp <= '0;
    end else begin
      s_act <= act;
      s_board <= board;
      s_bdisc <= in_disc(rx[CELL_LOG2-1:0], ry[CELL_LOG2-1:0]);
      s_cur <= cur;
      s_fall <= fall;
      s_hide <= hide;
      s_cp <= current_player;
    end

  assign rgb = !s_act ? 6'd0 : s_fall ? piece(a_player) :
               s_board ? (s_bdisc ? piece(s_hide ? 2'b00 : cell_rd_data) : BOARD) :
               s_cur ? piece(s_cp) : BG;

  always_ff @(posedge clk)
    if (rst) {vga_r, vga_g, vga_b} <= '0;
    else {vga_r, vga_g, vga_b} <= rgb;

  assign step_y = fall_y + 10'(FALL_STEP);
  assign landed = step_y >= target(a_row);

  always_comb begin
    state_n = state;
    fall_y_n = fall_y;
    done_n = 1'b0;
    if (state == IDLE && anim_start) begin
      fall_y_n = 10'(START_Y);
      state_n = 10'(START_Y) >= target(anim_row) ? LAND : FALL;
    end else if (state == FALL && frame_start) begin
      fall_y_n = landed ? target(a_row) : step_y;
      state_n = landed ? LAND : FALL;
    end else if (state == LAND && frame_start) begin
      state_n = IDLE;
      done_n = 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      fall_y <= '0;
      anim_done <= 1'b0;
      {a_col, a_row, a_player} <= '0;
    end else begin
      state <= state_n;
      fall_y <= fall_y_n;
      anim_done <= done_n;
      if (state == IDLE && anim_start) {a_col, a_row, a_player} <= {anim_col, anim_row, anim_player};
    end
endmodule

// File: doc/connect_four_renderer.md
# connect_four_renderer

Parametrised, pipelined pixel renderer for the Connect Four VGA path: turns the current pixel coordinate, board contents, cursor and game status into registered 2-bit-per-channel RGB. It sits between the VGA timing generator and the pad outputs. It generalises board geometry and adds a frame-locked drop animation and winning-line blink. The board is read through a 1-cycle-latency cell port rather than a flat vector, so board storage can scale.

## Interface
- ROWS, 8: board rows, 2..8; row 0 is the bottom row.
- COLS, 8: board columns, 2..8.
- CELL_LOG2, 5: cell size is 2^CELL_LOG2 pixels square.
- ORIGIN_X, 192: board left edge in pixels.
- ORIGIN_Y, 112: board top edge in pixels.
- RADIUS, 14: disc radius in pixels; must be below 2^(CELL_LOG2-1).
- FALL_STEP, 4: pixels a falling disc descends per frame.
- BLINK_LOG2, 4: winning discs toggle every 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- x_count, y_count  in  10 each  current pixel coordinate.
- frame_start  in  1  one-cycle pulse at pixel (0,0).
- cell_rd_row, cell_rd_col  out  3 each  combinational board read address for the current pixel.
- cell_rd_data  in  2  cell contents one cycle after the address: 00 empty, 01 P1, 10 P2.
- cursor_col  in  3  column under the cursor.
- current_player  in  2  01 P1, 10 P2.
- game_over  in  1  game ended.
- win_mask  in  ROWS*COLS  winning cells; bit row*COLS+col.
- anim_start  in  1  request a drop animation.
- anim_col, anim_row  in  3 each  column and target row of the drop.
- anim_player  in  2  colour of the falling disc.
- anim_busy  out  1  animation in progress.
- anim_done  out  1  one-cycle pulse when the disc lands.
- vga_r, vga_g, vga_b  out  2 each  registered colour.

## Operation
- Active area is x<640 and y<480. Outside it the colour is 000000.
- Board region: x in [ORIGIN_X, ORIGIN_X+COLS·2^CELL_LOG2), y in [ORIGIN_Y, ORIGIN_Y+ROWS·2^CELL_LOG2).
  - Address: col=(x−ORIGIN_X)>>CELL_LOG2, row=ROWS−1−((y−ORIGIN_Y)>>CELL_LOG2).
  - Outside the board region the address is 0 and the data is ignored.
- Disc test uses the in-cell offset o=x[CELL_LOG2-1:0] with dx=o−2^(CELL_LOG2-1); dy is computed the same way. A pixel is inside the disc when dx²+dy² ≤ RADIUS², computed in unsigned 2·CELL_LOG2+1 bits.
- Colours:
  - background 01/11/01
  - board 00/00/11
  - P1 11/11/00
  - P2 11/00/00
  - empty hole shows the background colour
- Board pixel outside a disc shows the board colour. Inside a disc it shows the piece colour, or the hole colour when the cell is empty.
- Cursor band: y in [ORIGIN_Y−16−2^CELL_LOG2, ORIGIN_Y−16), column==cursor_col. The disc is drawn in current_player colour. It is hidden when game_over=1 or anim_busy=1.
- Drop animation FSM, states IDLE, FALL, LAND:
  - IDLE: anim_start latches col, row and player, sets fall_y = cursor disc centre y, and moves to FALL. anim_busy rises the next cycle.
  - FALL: on each frame_start, fall_y += FALL_STEP. When fall_y ≥ target centre ORIGIN_Y+(ROWS−1−row)·2^CELL_LOG2+2^(CELL_LOG2-1), fall_y clamps to the target and the FSM moves to LAND.
  - LAND: on the next frame_start, pulse anim_done, clear anim_busy and return to IDLE.
  - anim_start while busy is ignored.
- The falling disc is drawn when |x−centre_x| and |y−fall_y| are both below 2^(CELL_LOG2-1) and the disc test passes. It overrides the board and cursor colours everywhere in the active area.
- The game logic writes the board cell only after anim_done.
- Priority, highest first: blanking, falling disc, board, cursor, background.

## Timing
- Fixed latency 2: RGB for a coordinate presented at cycle t appears at t+2.
  - Stage 0 decodes the region and issues the read address.
  - Stage 1 captures cell_rd_data and evaluates the disc tests.
  - Stage 2 registers the colour.
- The integrator delays hsync/vsync by 2 cycles.
- Reset values: vga_r, vga_g, vga_b = 00; anim_busy = 0; anim_done = 0; FSM in IDLE; fall_y = 0; blink counter = 0. The pipeline registers output black.
- Reset mid-animation aborts the animation with no anim_done.
- frame_start and anim_start in the same cycle: the animation latches, and the first step happens on the next frame_start.
- A target row whose start position already meets the target goes straight to LAND.

## Configuration
- CF_WIN_BLINK_EN defined:
  - A (BLINK_LOG2+1)-bit frame counter increments on each frame_start.
  - While game_over=1, disc pixels of cells with a win_mask bit set show the hole colour when the counter MSB is 1.
- Undefined: no counter; win_mask is ignored and winning discs are drawn steadily.

## Test plan
- Reset, then sweep x=207,y=127 (cell col0,row7 centre) with cell_rd_data=01 → vga=11/11/00 at t+2. At x=193,y=113 → 00/00/11.
- cursor_col=3, current_player=10, pixel (304,80) → 11/00/00. Same pixel with game_over=1 → 01/11/01.
- anim_start col2,row0,player01, FALL_STEP=4 → anim_busy=1. Target y=352 is reached after 68 frame_starts, then LAND; anim_done pulses on the 69th frame_start; the cursor is hidden throughout.
- anim_start while busy and rst mid-FALL → the second request is ignored; after rst, anim_busy=0 and no anim_done.
- CF_WIN_BLINK_EN, game_over=1, win_mask bit 0 set, cell data 10 → the disc alternates 11/00/00 and 01/11/01 every 16 frames. Without the macro it stays 11/00/00.
- Pixel (640,10) and (100,480) → 000000 regardless of other inputs.
